alu_mul_seq: RTL and testbench

- Sequencer that drives the 8-bit ALU as its initiator: it issues ADD operations to the ALU and captures the ALU result and carry.
- Performs unsigned 8x8 -> 16 shift-add multiplication; the ALU supplies the add and carry, and the shifts are done internally.
- Sits between game logic (score, mine-count arithmetic) and a dedicated ALU instance.
- Start/done handshake toward the requester; multi-cycle, one operation in flight.

---
 rtl/alu_mul_seq.sv | 113 +++++++++++
 tb/tb_alu_mul_seq.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/alu_mul_seq.sv
// Unsigned 8x8->16 shift-add multiplier that borrows an external ALU for the add step.
// Optional macro MUL_ZERO_BYPASS_EN: zero operands finish in one cycle without touching the ALU.
module alu_mul_seq #(
  parameter logic [2:0] OP_ADD = 3'b000,
  parameter int         ITER   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        ready,
  input  logic [7:0]  mcand,
  input  logic [7:0]  mplier,
  output logic [15:0] product,
  output logic        product_valid,
  output logic        done,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_op,
  input  logic [7:0]  alu_y,
  input  logic        alu_c
);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_SHIFT, S_DONE} state_t;

  localparam logic [3:0] ITER_CNT = 4'(ITER);

  state_t      state_q, state_d;
  logic [7:0]  m_q, m_d;
  logic [15:0] p_q, p_d;
  logic        carry_q, carry_d;
  logic [3:0]  count_q, count_d;
  logic        pvld_q, pvld_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      m_q     <= 8'h00;
      p_q     <= 16'h0000;
      carry_q <= 1'b0;
      count_q <= 4'd0;
      pvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      p_q     <= p_d;
      carry_q <= carry_d;
      count_q <= count_d;
      pvld_q  <= pvld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    p_d     = p_q;
    carry_d = carry_q;
    count_d = count_q;
    pvld_d  = pvld_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          m_d     = mcand;
          p_d     = {8'h00, mplier};
          count_d = ITER_CNT;
          carry_d = 1'b0;
          pvld_d  = 1'b0;
          state_d = S_ADD;
`ifdef MUL_ZERO_BYPASS_EN
          if (mcand == 8'h00 || mplier == 8'h00) begin
            p_d     = 16'h0000;
            count_d = 4'd0;
            pvld_d  = 1'b1;
            state_d = S_DONE;
          end
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADD: begin
        // Only add when the multiplier bit under examination is set.
        if (p_q[0]) begin
          p_d[15:8] = alu_y;
          carry_d   = alu_c;
        end else begin
          carry_d   = 1'b0;
        end
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        p_d     = {carry_q, p_q[15:1]};
        count_d = count_q - 4'd1;
        carry_d = 1'b0;
        if (count_q == 4'd1) begin
          pvld_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_ADD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ready         = (state_q == S_IDLE) || (state_q == S_DONE);
  assign done          = (state_q == S_DONE);
  assign product       = p_q;
  assign product_valid = pvld_q;
  assign alu_a         = (state_q == S_ADD) ? p_q[15:8] : 8'h00;
  assign alu_b         = m_q;
  assign alu_op        = OP_ADD;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with a behavioural 8-bit ALU attached.
module tb_alu_mul_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  mcand = 8'h00;
  logic [7:0]  mplier = 8'h00;
  logic        ready, product_valid, done, alu_c;
  logic [15:0] product;
  logic [7:0]  alu_a, alu_b, alu_y;
  logic [2:0]  alu_op;
  logic [8:0]  alu_sum;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc;

  always #5 clk = ~clk;

  assign alu_sum = (alu_op == 3'b000) ? ({1'b0, alu_a} + {1'b0, alu_b}) : 9'h000;
  assign alu_y   = alu_sum[7:0];
  assign alu_c   = alu_sum[8];

  alu_mul_seq dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready),
    .mcand(mcand), .mplier(mplier), .product(product),
    .product_valid(product_valid), .done(done),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_y(alu_y), .alu_c(alu_c)
  );

  // Present start for one cycle (cycle 0); returns at the negedge of cycle 1.
  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    mcand = a; mplier = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
  endtask

  task automatic wait_done();
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++; if (ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got %b want 1", ready); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", done); end
    tests_run++; if (product_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_pvld got %b want 0", product_valid); end
    tests_run++; if (product !== 16'h0000) begin tests_failed++; $display("FAIL reset_product got %h want 0000", product); end
    tests_run++; if ({alu_a, alu_b, alu_op} !== 19'h0) begin tests_failed++; $display("FAIL reset_alu got a=%h b=%h op=%b want 0/0/000", alu_a, alu_b, alu_op); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    issue(8'd13, 8'd11);
    tests_run++; if (ready !== 1'b0) begin tests_failed++; $display("FAIL busy_ready got %b want 0", ready); end
    wait_done();
    tests_run++; if (cyc != 17) begin tests_failed++; $display("FAIL basic_latency got %0d want 17", cyc); end
    tests_run++; if (product !== 16'h008F) begin tests_failed++; $display("FAIL basic_product got %h want 008f", product); end
    tests_run++; if (product_valid !== 1'b1 || ready !== 1'b1) begin tests_failed++; $display("FAIL basic_done_flags got pv=%b rdy=%b want 1/1", product_valid, ready); end
    @(negedge clk);
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL basic_done_pulse got %b want 0", done); end
    tests_run++; if (product_valid !== 1'b1 || product !== 16'h008F) begin tests_failed++; $display("FAIL basic_hold got pv=%b p=%h want 1/008f", product_valid, product); end
  endtask

  task automatic test_max();
    issue(8'd255, 8'd255);
    wait_done();
    tests_run++; if (cyc != 17) begin tests_failed++; $display("FAIL max_latency got %0d want 17", cyc); end
    tests_run++; if (product !== 16'hFE01) begin tests_failed++; $display("FAIL max_product got %h want fe01", product); end
  endtask

  task automatic test_zero();
    int exp_lat;
`ifdef MUL_ZERO_BYPASS_EN
    exp_lat = 1;
`else
    exp_lat = 17;
`endif
    issue(8'd0, 8'd77);
    wait_done();
    tests_run++; if (cyc != exp_lat) begin tests_failed++; $display("FAIL zero_latency got %0d want %0d", cyc, exp_lat); end
    tests_run++; if (product !== 16'h0000 || product_valid !== 1'b1) begin tests_failed++; $display("FAIL zero_product got p=%h pv=%b want 0000/1", product, product_valid); end
  endtask

  task automatic test_busy_start();
    issue(8'd6, 8'd7);
    while (!done && cyc < 60) begin
      if (cyc == 5 || cyc == 9) begin
        start = 1'b1; mcand = 8'd99; mplier = 8'd33;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    tests_run++; if (cyc != 17) begin tests_failed++; $display("FAIL busy_latency got %0d want 17", cyc); end
    tests_run++; if (product !== 16'd42) begin tests_failed++; $display("FAIL busy_product got %0d want 42", product); end
    @(negedge clk);
    tests_run++; if (done !== 1'b0 || ready !== 1'b1) begin tests_failed++; $display("FAIL busy_after got done=%b rdy=%b want 0/1", done, ready); end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    issue(8'd9, 8'd9);
    while (cyc < 8) begin @(negedge clk); cyc++; end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++; if (ready !== 1'b1 || product_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_flags got rdy=%b pv=%b want 1/0", ready, product_valid); end
    tests_run++; if (product !== 16'h0000 || done !== 1'b0) begin tests_failed++; $display("FAIL midrst_product got p=%h done=%b want 0000/0", product, done); end
    repeat (20) begin
      @(negedge clk);
      if (done) pulses++;
    end
    tests_run++; if (pulses != 0) begin tests_failed++; $display("FAIL midrst_no_done got %0d pulses want 0", pulses); end
  endtask

  task automatic test_back_to_back();
    issue(8'd2, 8'd5);
    wait_done();
    tests_run++; if (cyc != 17) begin tests_failed++; $display("FAIL b2b_latency1 got %0d want 17", cyc); end
    tests_run++; if (product !== 16'd10) begin tests_failed++; $display("FAIL b2b_product1 got %0d want 10", product); end
    mcand = 8'd3; mplier = 8'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc++;
    tests_run++; if (done !== 1'b0 || product_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_accept got done=%b pv=%b want 0/0", done, product_valid); end
    wait_done();
    tests_run++; if (cyc != 34) begin tests_failed++; $display("FAIL b2b_latency2 got %0d want 34", cyc); end
    tests_run++; if (product !== 16'd12) begin tests_failed++; $display("FAIL b2b_product2 got %0d want 12", product); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_busy_start();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
